// File: rtl/pattern_scan_controller.sv
// Serial pattern scanner: shifts a latched word through a programmable
// pattern matcher one bit per clock (LSB first), counts matches and
// reports the count plus the index of the first match.
module pattern_scan_controller #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PAT_W  = 2,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic [CNT_W-1:0]  out_first,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    localparam logic [CNT_W-1:0] FirstNone = '1;
    localparam logic [CNT_W-1:0] LastIdx   = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] MinIdx    = CNT_W'(PAT_W - 1);
    localparam logic [PAT_W-1:0] PatReset  = PAT_W'(1);

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   first_q, first_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic [CNT_W-1:0]   out_first_q, out_first_d;

    logic [PAT_W-1:0]   hist_scan;
    logic               hit;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            pattern_q   <= PatReset;
            hist_q      <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            first_q     <= FirstNone;
            out_count_q <= '0;
            out_first_q <= FirstNone;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            hist_q      <= hist_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            out_count_q <= out_count_d;
            out_first_q <= out_first_d;
        end
    end

    // Next-state logic: accept in IDLE, scan one bit per cycle, hold result in DONE
    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        hist_d      = hist_q;
        data_d      = data_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        out_count_d = out_count_q;
        out_first_d = out_first_q;

        // Newest bit enters at position 0; the shift drops the oldest bit
        hist_scan = (hist_q << 1) | PAT_W'(data_q[0]);
        // Early bits are ignored until the history holds a full pattern
        hit       = (hist_scan == pattern_q) && (idx_q >= MinIdx);

        unique case (state_q)
            StIdle: begin
                // Pattern write lands before the accepted word is scanned
                if (cfg_wr) begin
                    pattern_d = cfg_pattern;
                end
                if (in_valid) begin
                    data_d  = in_data;
                    hist_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    first_d = FirstNone;
                    state_d = StScan;
                end
            end
            StScan: begin
                hist_d = hist_scan;
                data_d = data_q >> 1;
                idx_d  = idx_q + CNT_W'(1);
                if (hit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == '0) begin
                        first_d = idx_q;
                    end
                end
                // Last bit: publish including any match on this bit
                if (idx_q == LastIdx) begin
                    out_count_d = cnt_d;
                    out_first_d = first_d;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Handshake and status outputs decoded from the state register
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        out_count = out_count_q;
        out_first = out_first_q;
    end

endmodule
